// File: rtl/grey_digit_gen_if.sv
// Control and code bus of the ring-grey digit generator.
// master drives run/dir/load/digit and receives the code and strobes;
// slave is the generator side.
interface grey_digit_gen_if;
    logic       i_run;
    logic       i_dir;
    logic       i_load;
    logic [3:0] i_digit;
    logic [4:0] o_grey;
    logic [3:0] o_digit;
    logic       o_step;
    logic       o_carry;

    modport master (
        output i_run,
        output i_dir,
        output i_load,
        output i_digit,
        input  o_grey,
        input  o_digit,
        input  o_step,
        input  o_carry
    );

    modport slave (
        input  i_run,
        input  i_dir,
        input  i_load,
        input  i_digit,
        output o_grey,
        output o_digit,
        output o_step,
        output o_carry
    );
endinterface

// File: rtl/grey_digit_gen.sv
// Ring-grey digit generator: prescaled up/down decimal counter that drives the
// registered 5-bit ring-grey code of the current digit plus step/carry strobes.
// Optional feature macro GREY_DP_EN: every wrap passes through the
// decimal-point code (10101, digit value 10) for one full step period.
module grey_digit_gen #(
    parameter int P_DIV   = 1000000,
    parameter int P_DIV_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    grey_digit_gen_if.slave   bus_io
);

    localparam logic [P_DIV_W-1:0] DIV_LAST = P_DIV_W'(P_DIV - 1);
    localparam logic [3:0]         DP_DIGIT = 4'd10;
    localparam logic [4:0]         GREY_RST = 5'b10001;

`ifdef GREY_DP_EN
    localparam logic [3:0] WRAP_UP   = DP_DIGIT;
    localparam logic [3:0] WRAP_DOWN = DP_DIGIT;
`else
    localparam logic [3:0] WRAP_UP   = 4'd0;
    localparam logic [3:0] WRAP_DOWN = 4'd9;
`endif

    // Ring-grey code of a state; digit value 10 is the decimal-point code.
    function automatic logic [4:0] grey_of(input logic [3:0] d);
        logic [4:0] g;
        case (d)
            4'd0:    g = 5'b10001;
            4'd1:    g = 5'b00001;
            4'd2:    g = 5'b00011;
            4'd3:    g = 5'b00010;
            4'd4:    g = 5'b00110;
            4'd5:    g = 5'b00100;
            4'd6:    g = 5'b01100;
            4'd7:    g = 5'b01000;
            4'd8:    g = 5'b11000;
            4'd9:    g = 5'b10000;
`ifdef GREY_DP_EN
            4'd10:   g = 5'b10101;
`endif
            default: g = GREY_RST;
        endcase
        return g;
    endfunction

    logic [P_DIV_W-1:0] presc_q, presc_d;
    logic [3:0]         digit_q, digit_d;
    logic [4:0]         grey_q,  grey_d;
    logic               step_q,  step_d;
    logic               carry_q, carry_d;

    logic               step_cycle;
    logic               load_ok;

    // Next state: a valid load wins over a step; a step advances the digit
    // in the direction sampled in the step cycle and flags wraps.
    always_comb begin
        step_cycle = bus_io.i_run && (presc_q == DIV_LAST);
        load_ok    = bus_io.i_load && (bus_io.i_digit <= 4'd9);
        presc_d    = presc_q;
        digit_d    = digit_q;
        step_d     = 1'b0;
        carry_d    = 1'b0;

        if (load_ok) begin
            digit_d = bus_io.i_digit;
            presc_d = '0;
        end else if (step_cycle) begin
            presc_d = '0;
            step_d  = 1'b1;
            if (!bus_io.i_dir) begin
                if (digit_q == 4'd9) begin
                    digit_d = WRAP_UP;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == 4'd0) begin
                    digit_d = WRAP_DOWN;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
`ifdef GREY_DP_EN
            // Leaving the decimal point is an ordinary step, never a carry.
            if (digit_q == DP_DIGIT) begin
                digit_d = bus_io.i_dir ? 4'd9 : 4'd0;
                carry_d = 1'b0;
            end
`endif
        end else if (bus_io.i_run) begin
            presc_d = presc_q + 1'b1;
        end

        grey_d = grey_of(digit_d);
    end

    // State and output registers; code and digit always update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
            digit_q <= 4'd0;
            grey_q  <= GREY_RST;
            step_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            grey_q  <= grey_d;
            step_q  <= step_d;
            carry_q <= carry_d;
        end
    end

    assign bus_io.o_grey  = grey_q;
    assign bus_io.o_digit = digit_q;
    assign bus_io.o_step  = step_q;
    assign bus_io.o_carry = carry_q;

endmodule
